// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue: owns the fetch PC, reads the combinational ROM,
// buffers up to DEPTH {pc, inst} pairs and hands them to the core via valid/ready.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          rom_ce_o,
  output logic [31:0]   rom_addr_o,
  input  logic [31:0]   rom_inst_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          if_valid_o,
  input  logic          if_ready_i,
  output logic [31:0]   if_pc_o,
  output logic [31:0]   if_inst_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [31:0]   inst_mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          full_s;
  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic [31:0]   head_pc_s;
  logic [31:0]   head_inst_s;

  // Handshake decode and head-entry output mux (masked to zero when not valid)
  always_comb begin
    full_s      = (count_r == CW'(DEPTH));
    valid_s     = (count_r != '0) && !redirect_i && !rst;
    pop_s       = valid_s && if_ready_i;
    push_s      = !rst && !redirect_i && (!full_s || pop_s);
    head_pc_s   = 32'h0000_0000;
    head_inst_s = 32'h0000_0000;
    if (valid_s) begin
      head_pc_s   = pc_mem_r[head_r];
      head_inst_s = inst_mem_r[head_r];
    end else begin
      head_pc_s   = 32'h0000_0000;
      head_inst_s = 32'h0000_0000;
    end
  end

  // Fetch PC, queue pointers and occupancy; reset beats redirect beats normal flow
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
    end else if (redirect_i) begin
      fetch_pc_r <= redirect_pc_i & 32'hFFFF_FFFC;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
    end else begin
      if (push_s) begin
        tail_r     <= tail_r + PW'(1);
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage is not reset; contents are only observable through valid_s
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[tail_r]   <= fetch_pc_r;
      inst_mem_r[tail_r] <= rom_inst_i;
    end
  end

  assign rom_ce_o   = push_s;
  assign rom_addr_o = fetch_pc_r;
  assign if_valid_o = valid_s;
  assign if_pc_o    = head_pc_s;
  assign if_inst_o  = head_inst_s;
  assign count_o    = count_r;

endmodule

// File: doc/inst_prefetch_buffer.md
Name: inst_prefetch_buffer

Overview:
- Instruction prefetch queue between the instruction ROM and the core fetch stage.
- Owns the fetch PC and drives the combinational instruction ROM port (ce/addr in, inst out in the same cycle).
- Buffers up to DEPTH {pc, inst} pairs and hands them to the core over a valid/ready handshake.
- Flushes and restarts on a redirect (branch/jump/exception) from the core.

Parameters:
DEPTH, 4, number of queue entries; power of two, >=2
RESET_PC, 32'h1c00_0000, fetch PC loaded on reset
CW, $clog2(DEPTH)+1, width of the occupancy count (derived; not to be overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
rom_ce_o  output  1  instruction ROM chip enable
rom_addr_o  output  32  instruction ROM byte address (always word aligned)
rom_inst_i  input  32  ROM instruction, valid in the same cycle as rom_ce_o/rom_addr_o
redirect_i  input  1  flush queue and restart fetch at redirect_pc_i
redirect_pc_i  input  32  new fetch address; bits [1:0] ignored
if_valid_o  output  1  head entry valid toward core
if_ready_i  input  1  core accepts head entry
if_pc_o  output  32  PC of head entry
if_inst_o  output  32  instruction of head entry
count_o  output  CW  current occupancy, 0..DEPTH

Behaviour:
- State: fetch_pc (32b), DEPTH-entry array of {pc, inst}, head/tail pointers (log2 DEPTH bits, natural wrap), count (CW bits).
- pop = if_valid_o & if_ready_i.
- push = !rst & !redirect_i & (count < DEPTH | pop).
- rom_ce_o = push (combinational). rom_addr_o = fetch_pc in every cycle, whether or not rom_ce_o is asserted.
- On push: entry[tail] <= {fetch_pc, rom_inst_i}; tail += 1; fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
- On pop: head += 1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full queue: push is allowed only in a cycle with a simultaneous pop. Otherwise rom_ce_o = 0 and fetch_pc holds.
- Empty queue: if_valid_o = 0. A freshly pushed entry is not bypassed; it appears at if_valid_o one cycle after its push, so fetch-to-output latency is 1 cycle.
- Output mux:
  - if_valid_o = (count != 0) & !redirect_i.
  - if_pc_o / if_inst_o = entry[head] when if_valid_o = 1, else 32'h0.
- Redirect cycle (redirect_i = 1):
  - if_valid_o is forced 0, so no pop occurs; rom_ce_o = 0.
  - Next edge: count, head, tail <= 0; fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - Normal fetch resumes the following cycle. The first redirected instruction is valid 2 cycles after redirect_i is asserted.
- Back-to-back redirects: the last one wins; each restarts the sequence above.
- Reset (rst = 1, synchronous):
  - rom_ce_o = 0 and if_valid_o = 0 combinationally while rst is high.
  - Next edge: count, head, tail <= 0; fetch_pc <= RESET_PC.
  - Reset overrides a redirect and a pop in the same cycle.
  - Reset mid-operation (full or partial queue) discards all entries.
- Output reset values: rom_ce_o 0, rom_addr_o RESET_PC (after the first reset edge), if_valid_o 0, if_pc_o 0, if_inst_o 0, count_o 0.
- Entry array contents need not be reset; outputs are masked by if_valid_o.
- No combinational path from if_ready_i to rom_addr_o. The path if_ready_i -> rom_ce_o (via pop) is permitted.

Test Plan:
1. Reset, then if_ready_i=1 continuously, ROM returns addr^32'hA5A5A5A5 -> rom_ce_o=1 every cycle from the first post-reset cycle; if_pc_o = 1c000000, 1c000004, 1c000008 on consecutive cycles starting one cycle later; if_inst_o matches; count_o stays 1.
2. if_ready_i=0 after reset -> count_o = 1,2,3,4 over 4 cycles; then rom_ce_o=0 and rom_addr_o holds 1c000010. Then if_ready_i=1 for one cycle -> pop 1c000000 and push 1c000010 in the same cycle; count_o stays 4.
3. With 3 entries queued, pulse redirect_i one cycle with redirect_pc_i=1c000100 -> if_valid_o=0 and rom_ce_o=0 that cycle; count_o=0 next cycle with rom_addr_o=1c000100, rom_ce_o=1; if_valid_o=1 with if_pc_o=1c000100 the cycle after.
4. Redirect to 1c000103 -> first fetched and delivered PC is 1c000100. Redirect to FFFFFFFC with ready=1 -> delivered PCs FFFFFFFC then 00000000.
5. Queue full, assert rst for one cycle together with redirect_i=1 and if_ready_i=1 -> rom_ce_o=0 and if_valid_o=0 during rst; next cycle count_o=0 and rom_addr_o=1c000000 (RESET_PC, not the redirect target); fetch restarts there.
6. Random if_ready_i (50%) over 1000 cycles with periodic redirects -> scoreboard: delivered PCs are strictly sequential (+4) between redirects; no PC lost or duplicated; count_o never exceeds 4; no pop ever occurs while if_valid_o=0.
